// File: rtl/fft_1_pkg.sv
// Shared constants, state encoding and latency helper for the 16-point FFT sequencer.
package fft_1_pkg;

  localparam int LOG2N       = 4;
  localparam int N           = 1 << LOG2N;
  localparam int HALF_N      = N / 2;
  localparam int STAGE_W     = $clog2(LOG2N);
  localparam int RAM_LAT_DEF = 1;
  localparam int MUL_LAT_DEF = 1;

  // The drain gap lets the last write-back of a stage land before the next stage reads.
  function automatic int drainCycles(input int ramLat, input int mulLat);
    return ramLat + mulLat + 1;
  endfunction

  localparam int DRAIN_CYC = drainCycles(RAM_LAT_DEF, MUL_LAT_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fft_1_ctrl_if.sv
// Control/RAM-side bundle of the FFT sequencer; master is the controller.
interface fft_1_ctrl_if;
  import fft_1_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [STAGE_W-1:0]   stage;
  logic                 rd_en_n;
  logic [LOG2N-1:0]     rd_addr_n;
  logic                 rd_en_m;
  logic [LOG2N-1:0]     rd_addr_m;
  logic [LOG2N-2:0]     tw_index;
  logic                 wr_en;
  logic [LOG2N-1:0]     wr_addr_m;
  logic [LOG2N-1:0]     wr_addr_n;
  logic                 scale;

  modport master (
    input  start,
    output busy, done, stage,
    output rd_en_n, rd_addr_n, rd_en_m, rd_addr_m,
    output tw_index, wr_en, wr_addr_m, wr_addr_n, scale
  );

  modport slave (
    output start,
    input  busy, done, stage,
    input  rd_en_n, rd_addr_n, rd_en_m, rd_addr_m,
    input  tw_index, wr_en, wr_addr_m, wr_addr_n, scale
  );

endinterface

// File: rtl/fft_1_addr_gen.sv
// In-place radix-2 DIT addressing: (stage, butterfly) -> (upper a, lower n, twiddle).
module fft_1_addr_gen
  import fft_1_pkg::*;
(
  input  logic [STAGE_W-1:0] i_stage,
  input  logic [LOG2N-2:0]   i_b,
  output logic [LOG2N-1:0]   o_a,
  output logic [LOG2N-1:0]   o_n,
  output logic [LOG2N-2:0]   o_tw
);

  logic [LOG2N-1:0] w_bExt;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;

  // Groups are 2*half apart; the twiddle stride shrinks as the span grows.
  always_comb begin
    w_bExt = {1'b0, i_b};
    w_half = LOG2N'(1) << i_stage;
    w_pos  = w_bExt & (w_half - 1'b1);
    w_grp  = w_bExt >> i_stage;
    o_a    = ((w_grp << i_stage) << 1) | w_pos;
    o_n    = o_a + w_half;
    o_tw   = w_pos[LOG2N-2:0] << (STAGE_W'(LOG2N - 1) - i_stage);
  end

endmodule

// File: rtl/fft_1_ctrl.sv
// Stage/butterfly sequencer for the 16-point in-place FFT around butterfly_1.
// Build option FFT_1_CTRL_SCALE_EN drives scale with every write-back.
module fft_1_ctrl
  import fft_1_pkg::*;
#(
  parameter int RAM_LAT = RAM_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
)
(
  input  logic          clk,
  input  logic          rst,
  fft_1_ctrl_if.master  bus
);

  localparam int WR_LAT    = RAM_LAT + MUL_LAT;
  localparam int DRAIN_LEN = drainCycles(RAM_LAT, MUL_LAT);
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  localparam logic [LOG2N-2:0]   LAST_B     = (LOG2N-1)'(HALF_N - 1);
  localparam logic [DRAIN_W-1:0] LAST_D     = DRAIN_W'(DRAIN_LEN - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [LOG2N-2:0]   r_bIdx;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic [STAGE_W-1:0] r_stage;
  logic [LOG2N-1:0]   r_lastN;

  logic               w_issue;
  logic [LOG2N-1:0]   w_a;
  logic [LOG2N-1:0]   w_n;
  logic [LOG2N-2:0]   w_tw;

  logic [MUL_LAT-1:0] r_mVld;
  logic [LOG2N-1:0]   r_mAddr [MUL_LAT];
  logic [RAM_LAT-1:0] r_tVld;
  logic [LOG2N-2:0]   r_tw    [RAM_LAT];
  logic [WR_LAT-1:0]  r_wVld;
  logic [LOG2N-1:0]   r_wAddrM [WR_LAT];
  logic [LOG2N-1:0]   r_wAddrN [WR_LAT];

  fft_1_addr_gen u_addrGen (
    .i_stage (r_stage),
    .i_b     (r_bIdx),
    .o_a     (w_a),
    .o_n     (w_n),
    .o_tw    (w_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (r_bIdx == LAST_B) w_nextState = DRAIN;
      DRAIN:   if (r_drainCnt == LAST_D)
                 w_nextState = (r_stage == LAST_STAGE) ? DONE : RUN;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Stage advances on leaving DRAIN so it is already new in the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bIdx     <= '0;
      r_drainCnt <= '0;
      r_stage    <= '0;
      r_lastN    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bIdx     <= '0;
          r_drainCnt <= '0;
          r_stage    <= '0;
        end
        RUN: begin
          r_bIdx  <= r_bIdx + 1'b1;
          r_lastN <= w_n;
        end
        DRAIN: begin
          if (r_drainCnt == LAST_D) begin
            r_drainCnt <= '0;
            if (r_stage != LAST_STAGE) r_stage <= r_stage + 1'b1;
          end else begin
            r_drainCnt <= r_drainCnt + 1'b1;
          end
        end
        DONE:    r_stage <= '0;
        default: r_stage <= '0;
      endcase
    end
  end

  // Valid-tagged delay lines; payload only moves with a valid so outputs hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mVld <= '0;
      r_tVld <= '0;
      r_wVld <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_mAddr[i] <= '0;
      for (int i = 0; i < RAM_LAT; i++) r_tw[i] <= '0;
      for (int i = 0; i < WR_LAT; i++) begin
        r_wAddrM[i] <= '0;
        r_wAddrN[i] <= '0;
      end
    end else begin
      r_mVld[0] <= w_issue;
      r_tVld[0] <= w_issue;
      r_wVld[0] <= w_issue;
      if (w_issue) begin
        r_mAddr[0]  <= w_a;
        r_tw[0]     <= w_tw;
        r_wAddrM[0] <= w_a;
        r_wAddrN[0] <= w_n;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        r_mVld[i] <= r_mVld[i-1];
        if (r_mVld[i-1]) r_mAddr[i] <= r_mAddr[i-1];
      end
      for (int i = 1; i < RAM_LAT; i++) begin
        r_tVld[i] <= r_tVld[i-1];
        if (r_tVld[i-1]) r_tw[i] <= r_tw[i-1];
      end
      for (int i = 1; i < WR_LAT; i++) begin
        r_wVld[i] <= r_wVld[i-1];
        if (r_wVld[i-1]) begin
          r_wAddrM[i] <= r_wAddrM[i-1];
          r_wAddrN[i] <= r_wAddrN[i-1];
        end
      end
    end
  end

  assign w_issue       = (r_state == RUN);
  assign bus.busy      = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done      = (r_state == DONE);
  assign bus.stage     = r_stage;
  assign bus.rd_en_n   = w_issue;
  assign bus.rd_addr_n = w_issue ? w_n : r_lastN;
  assign bus.rd_en_m   = r_mVld[MUL_LAT-1];
  assign bus.rd_addr_m = r_mAddr[MUL_LAT-1];
  assign bus.tw_index  = r_tw[RAM_LAT-1];
  assign bus.wr_en     = r_wVld[WR_LAT-1];
  assign bus.wr_addr_m = r_wAddrM[WR_LAT-1];
  assign bus.wr_addr_n = r_wAddrN[WR_LAT-1];

`ifdef FFT_1_CTRL_SCALE_EN
  assign bus.scale = r_wVld[WR_LAT-1];
`else
  assign bus.scale = 1'b0;
`endif

endmodule

// File: tb/tb_fft_1_ctrl.sv
// Directed bench for fft_1_ctrl: timing, addressing, restart rules and an impulse FFT
// through a behavioural RAM + butterfly. Honours FFT_1_CTRL_SCALE_EN for the expected gain.
module tb_fft_1_ctrl;

  logic clk;
  logic rst;
  bit   ramInit;

  int checks = 0;
  int errors = 0;

  int holdN = 0, holdM = 0, holdTw = 0, holdWm = 0, holdWn = 0;

`ifdef FFT_1_CTRL_SCALE_EN
  localparam bit SCALE_ON = 1'b1;
  localparam int SCALE_SHIFT = 1;
  localparam int EXP_BIN = 6;
`else
  localparam bit SCALE_ON = 1'b0;
  localparam int SCALE_SHIFT = 0;
  localparam int EXP_BIN = 100;
`endif

  fft_1_ctrl_if ctrlBus ();

  fft_1_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ctrlBus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural sample RAM and butterfly with a Q14 twiddle table, W^k = exp(-j*2*pi*k/16).
  int twC [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int twS [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};
  int ramRe [16];
  int ramIm [16];
  int dnRe, dnIm, dmRe, dmIm, prodRe, prodIm;
  int sumRe, sumIm, difRe, difIm;

  always_comb begin
    sumRe = (dmRe + prodRe) >>> SCALE_SHIFT;
    sumIm = (dmIm + prodIm) >>> SCALE_SHIFT;
    difRe = (dmRe - prodRe) >>> SCALE_SHIFT;
    difIm = (dmIm - prodIm) >>> SCALE_SHIFT;
  end

  always @(posedge clk) begin
    if (ramInit) begin
      for (int k = 0; k < 16; k++) begin
        ramRe[k] <= (k == 0) ? 100 : 0;
        ramIm[k] <= 0;
      end
    end else if (ctrlBus.wr_en === 1'b1) begin
      ramRe[ctrlBus.wr_addr_m] <= sumRe;
      ramIm[ctrlBus.wr_addr_m] <= sumIm;
      ramRe[ctrlBus.wr_addr_n] <= difRe;
      ramIm[ctrlBus.wr_addr_n] <= difIm;
    end
    if (ctrlBus.rd_en_n === 1'b1) begin
      dnRe <= ramRe[ctrlBus.rd_addr_n];
      dnIm <= ramIm[ctrlBus.rd_addr_n];
    end
    if (ctrlBus.rd_en_m === 1'b1) begin
      dmRe <= ramRe[ctrlBus.rd_addr_m];
      dmIm <= ramIm[ctrlBus.rd_addr_m];
    end
    prodRe <= (dnRe * twC[ctrlBus.tw_index] + dnIm * twS[ctrlBus.tw_index]) >>> 14;
    prodIm <= (dnIm * twC[ctrlBus.tw_index] - dnRe * twS[ctrlBus.tw_index]) >>> 14;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference addressing written as the textbook group/position double loop.
  task automatic addrModel(input int s, input int b, output int a, output int n, output int tw);
    int half, cnt;
    half = 1 << s;
    cnt  = 0;
    a = 0; n = 0; tw = 0;
    for (int base = 0; base < 16; base += 2 * half) begin
      for (int j = 0; j < half; j++) begin
        if (cnt == b) begin
          a  = base + j;
          n  = a + half;
          tw = j * (8 >> s);
        end
        cnt++;
      end
    end
  endtask

  // One transform, start accepted in the current cycle (cycle 0); returns in cycle 46.
  task automatic applyStimulus(input bit pulses);
    int  wrCount, doneCount, lastWr, s, a, n, tw;
    int  lastWrStage [4];
    int  firstRd [4];
    bit  run, v1, v2;
    int  a1, n1, tw1, a2, n2;
    wrCount = 0; doneCount = 0; lastWr = -1;
    v1 = 0; v2 = 0; a1 = 0; n1 = 0; tw1 = 0; a2 = 0; n2 = 0;
    for (int k = 0; k < 4; k++) begin
      lastWrStage[k] = -1;
      firstRd[k]     = -1;
    end
    ctrlBus.start = 1'b1;
    tick();
    ctrlBus.start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      run = (c <= 44) && (((c - 1) % 11) < 8);
      s   = (c <= 44) ? (c - 1) / 11 : 3;
      a = 0; n = 0; tw = 0;
      if (run) begin
        addrModel(s, (c - 1) % 11, a, n, tw);
        holdN = n;
      end
      if (v1) begin
        holdM  = a1;
        holdTw = tw1;
      end
      if (v2) begin
        holdWm = a2;
        holdWn = n2;
      end
      checkOutput($sformatf("busy@%0d", c), ctrlBus.busy, c <= 44);
      checkOutput($sformatf("done@%0d", c), ctrlBus.done, c == 45);
      if (c <= 44) checkOutput($sformatf("stage@%0d", c), ctrlBus.stage, s);
      checkOutput($sformatf("rdEnN@%0d", c), ctrlBus.rd_en_n, run);
      checkOutput($sformatf("rdAddrN@%0d", c), ctrlBus.rd_addr_n, holdN);
      checkOutput($sformatf("rdEnM@%0d", c), ctrlBus.rd_en_m, v1);
      checkOutput($sformatf("rdAddrM@%0d", c), ctrlBus.rd_addr_m, holdM);
      checkOutput($sformatf("twIndex@%0d", c), ctrlBus.tw_index, holdTw);
      checkOutput($sformatf("wrEn@%0d", c), ctrlBus.wr_en, v2);
      checkOutput($sformatf("wrAddrM@%0d", c), ctrlBus.wr_addr_m, holdWm);
      checkOutput($sformatf("wrAddrN@%0d", c), ctrlBus.wr_addr_n, holdWn);
      checkOutput($sformatf("scale@%0d", c), ctrlBus.scale, SCALE_ON ? v2 : 1'b0);
      if (ctrlBus.wr_en === 1'b1) begin
        wrCount++;
        lastWr = c;
        if (c >= 3 && c <= 46) lastWrStage[(c - 3) / 11] = c;
      end
      if ((ctrlBus.rd_en_n === 1'b1 || ctrlBus.rd_en_m === 1'b1) && c <= 44 && firstRd[s] < 0)
        firstRd[s] = c;
      if (ctrlBus.done === 1'b1) doneCount++;
      v2 = v1; a2 = a1; n2 = n1;
      v1 = run; a1 = a; n1 = n; tw1 = tw;
      ctrlBus.start = pulses && (c == 5 || c == 30);
      tick();
    end
    ctrlBus.start = 1'b0;
    checkOutput("wrPulseCount", wrCount, 32);
    checkOutput("lastWrCycle", lastWr, 43);
    checkOutput("doneCount", doneCount, 1);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("readAfterWrite%0d", k), firstRd[k+1] > lastWrStage[k], 1'b1);
    checkOutput("idleBusy", ctrlBus.busy, 1'b0);
    checkOutput("idleDone", ctrlBus.done, 1'b0);
    checkOutput("idleStage", ctrlBus.stage, 0);
  endtask

  initial begin
    int doneCycle;
    rst = 1'b1;
    ctrlBus.start = 1'b0;
    ramInit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput($sformatf("resetOutputs@%0d", c),
                  {ctrlBus.busy, ctrlBus.done, ctrlBus.stage, ctrlBus.rd_en_n, ctrlBus.rd_addr_n,
                   ctrlBus.rd_en_m, ctrlBus.rd_addr_m, ctrlBus.tw_index, ctrlBus.wr_en,
                   ctrlBus.wr_addr_m, ctrlBus.wr_addr_n, ctrlBus.scale}, 0);
    end

    ramInit = 1'b1;
    tick();
    ramInit = 1'b0;

    $display("[TB] golden impulse transform");
    applyStimulus(1'b0);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("binRe%0d", k), ramRe[k], EXP_BIN);
      checkOutput($sformatf("binIm%0d", k), ramIm[k], 0);
    end

    $display("[TB] back-to-back transform with ignored start pulses");
    applyStimulus(1'b1);

    $display("[TB] reset mid-transform then restart");
    ctrlBus.start = 1'b1;
    tick();
    ctrlBus.start = 1'b0;
    repeat (19) tick();
    checkOutput("wrBeforeReset", ctrlBus.wr_en, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("wrAtReset", ctrlBus.wr_en, 1'b0);
    checkOutput("busyAtReset", ctrlBus.busy, 1'b0);
    checkOutput("rdEnNAtReset", ctrlBus.rd_en_n, 1'b0);
    tick();
    checkOutput("wrHeldReset", ctrlBus.wr_en, 1'b0);
    rst = 1'b0;
    ctrlBus.start = 1'b1;
    tick();
    ctrlBus.start = 1'b0;
    checkOutput("restartBusy", ctrlBus.busy, 1'b1);
    checkOutput("restartRdEnN", ctrlBus.rd_en_n, 1'b1);
    checkOutput("restartRdAddrN", ctrlBus.rd_addr_n, 1);
    checkOutput("restartStage", ctrlBus.stage, 0);
    doneCycle = -1;
    for (int k = 1; k <= 60; k++) begin
      if (ctrlBus.done === 1'b1) begin
        doneCycle = k;
        break;
      end
      tick();
    end
    checkOutput("restartDoneCycle", doneCycle, 45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
